// File: rtl/mega_drive_pad_pkg.sv
// Shared constants, types and the pin-map helper for the Mega Drive pad responder.
package mega_drive_pad_pkg;

    localparam int NUM_BUTTONS     = 12;
    localparam int PHASE_W         = 3;
    localparam int DEFAULT_TIMEOUT = 75000;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;

    typedef enum logic [PHASE_W-1:0] {
        PH_0 = 3'd0,
        PH_1 = 3'd1,
        PH_2 = 3'd2,
        PH_3 = 3'd3,
        PH_4 = 3'd4,
        PH_5 = 3'd5,
        PH_6 = 3'd6,
        PH_7 = 3'd7
    } phase_e;

    typedef struct packed {
        logic p9;
        logic p6;
        logic p4;
        logic p3;
        logic p2;
        logic p1;
    } pins_t;

    // Three-button pads never see the extended phases, so fold 5..7 onto 1..3.
    function automatic pins_t pad_map(
        input phase_e                 phase,
        input logic                   six,
        input logic [NUM_BUTTONS-1:0] btn
    );
        pins_t              m;
        logic [PHASE_W-1:0] ph;
        ph = phase;
        if (!six && ph > PH_4) begin
            ph = ph - PHASE_W'(4);
        end
        m = '1;
        unique case (ph)
            PH_0, PH_2, PH_4: begin
                m.p1 = ~btn[BTN_UP];
                m.p2 = ~btn[BTN_DOWN];
                m.p3 = ~btn[BTN_LEFT];
                m.p4 = ~btn[BTN_RIGHT];
                m.p6 = ~btn[BTN_B];
                m.p9 = ~btn[BTN_C];
            end
            PH_1, PH_3: begin
                m.p1 = ~btn[BTN_UP];
                m.p2 = ~btn[BTN_DOWN];
                m.p3 = 1'b0;
                m.p4 = 1'b0;
                m.p6 = ~btn[BTN_A];
                m.p9 = ~btn[BTN_START];
            end
            PH_5: begin
                m.p1 = 1'b0;
                m.p2 = 1'b0;
                m.p3 = 1'b0;
                m.p4 = 1'b0;
                m.p6 = ~btn[BTN_A];
                m.p9 = ~btn[BTN_START];
            end
            PH_6: begin
                m.p1 = ~btn[BTN_Z];
                m.p2 = ~btn[BTN_Y];
                m.p3 = ~btn[BTN_X];
                m.p4 = ~btn[BTN_MODE];
                m.p6 = ~btn[BTN_B];
                m.p9 = ~btn[BTN_C];
            end
            PH_7: begin
                m.p1 = 1'b1;
                m.p2 = 1'b1;
                m.p3 = 1'b1;
                m.p4 = 1'b1;
                m.p6 = ~btn[BTN_A];
                m.p9 = ~btn[BTN_START];
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pad_select_sync.sv
// Two-flop synchronizer for the pad Select line plus a change detector.
module pad_select_sync (
    input  logic clk,
    input  logic rst,
    input  logic sel_async,
    output logic sel_s2,
    output logic sel_edge
);

    logic sel_s1_q;
    logic sel_s1_d;
    logic sel_s2_q;
    logic sel_s2_d;
    logic sel_prev_q;
    logic sel_prev_d;

    always_comb begin
        sel_s1_d   = sel_async;
        sel_s2_d   = sel_s1_q;
        sel_prev_d = sel_s2_q;
    end

    // Idle Select is high, so reset to high to avoid a false edge on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_s1_q   <= 1'b1;
            sel_s2_q   <= 1'b1;
            sel_prev_q <= 1'b1;
        end else begin
            sel_s1_q   <= sel_s1_d;
            sel_s2_q   <= sel_s2_d;
            sel_prev_q <= sel_prev_d;
        end
    end

    assign sel_s2   = sel_s2_q;
    assign sel_edge = sel_s2_q ^ sel_prev_q;

endmodule

// File: rtl/mega_drive_pad_responder.sv
// Mega Drive controller emulation: tracks Select phases and drives the
// active-low pad pins, including six-button identification phases.
module mega_drive_pad_responder
    import mega_drive_pad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES     = DEFAULT_TIMEOUT,
    parameter bit SIX_BUTTON_DEFAULT = 1'b1
) (
    input  logic                   Clock50,
    input  logic                   Reset,
    input  logic                   Select,
    input  logic [NUM_BUTTONS-1:0] Buttons,
    input  logic                   SixButtonEn,
    output logic                   Pino1,
    output logic                   Pino2,
    output logic                   Pino3,
    output logic                   Pino4,
    output logic                   Pino6,
    output logic                   Pino9,
    output logic [PHASE_W-1:0]     Phase
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic       sel_s2;
    logic       sel_edge;
    phase_e     phase_q;
    phase_e     phase_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic       six_q;
    logic       six_d;
    pins_t      pins_q;
    pins_t      pins_d;

    pad_select_sync u_sync (
        .clk       (Clock50),
        .rst       (Reset),
        .sel_async (Select),
        .sel_s2    (sel_s2),
        .sel_edge  (sel_edge)
    );

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        six_d   = six_q;
        if (phase_q == PH_0) begin
            six_d = SixButtonEn;
        end
        // An edge outranks a coincident timeout.
        if (sel_edge) begin
            phase_d = phase_e'(phase_q + PHASE_W'(1));
            cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
            phase_d = sel_s2 ? PH_0 : PH_1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        pins_d = pad_map(phase_d, six_q, Buttons);
    end

    always_ff @(posedge Clock50) begin
        if (Reset) begin
            phase_q <= PH_0;
            cnt_q   <= '0;
            six_q   <= SIX_BUTTON_DEFAULT;
            pins_q  <= '1;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            six_q   <= six_d;
            pins_q  <= pins_d;
        end
    end

    assign Pino1 = pins_q.p1;
    assign Pino2 = pins_q.p2;
    assign Pino3 = pins_q.p3;
    assign Pino4 = pins_q.p4;
    assign Pino6 = pins_q.p6;
    assign Pino9 = pins_q.p9;
    assign Phase = phase_q;

endmodule

// File: tb/tb_mega_drive_pad_responder.sv
// Scoreboard bench for mega_drive_pad_responder with directed Select sequences.
module tb_mega_drive_pad_responder;

    localparam int T  = 1000;
    localparam int HP = 250;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Select;
    logic [11:0] Buttons;
    logic        SixButtonEn;
    logic        Pino1, Pino2, Pino3, Pino4, Pino6, Pino9;
    logic [2:0]  Phase;

    mega_drive_pad_responder #(
        .TIMEOUT_CYCLES     (T),
        .SIX_BUTTON_DEFAULT (1'b1)
    ) dut (
        .Clock50     (clk),
        .Reset       (Reset),
        .Select      (Select),
        .Buttons     (Buttons),
        .SixButtonEn (SixButtonEn),
        .Pino1       (Pino1),
        .Pino2       (Pino2),
        .Pino3       (Pino3),
        .Pino4       (Pino4),
        .Pino6       (Pino6),
        .Pino9       (Pino9),
        .Phase       (Phase)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [5:0] pins;
        logic [2:0] ph;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic expect_at(input int dly, input logic [5:0] p,
                             input logic [2:0] ph, input string nm);
        exp_t e;
        e.at   = cyc + dly;
        e.pins = p;
        e.ph   = ph;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // pins packed as {Pino9,Pino6,Pino4,Pino3,Pino2,Pino1}
    always @(negedge clk) begin
        logic [5:0] act;
        act = {Pino9, Pino6, Pino4, Pino3, Pino2, Pino1};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at <= cyc) begin
                n_chk++;
                if (q[i].at == cyc && act === q[i].pins && Phase === q[i].ph)
                    n_pass++;
                else
                    $display("FAIL %s: pins=%b phase=%0d, expected pins=%b phase=%0d (cycle %0d)",
                             q[i].name, act, Phase, q[i].pins, q[i].ph, cyc);
                q.delete(i);
            end
        end
    end

    task automatic do_reset(input logic [5:0] post, input string nm);
        Reset = 1'b1;
        expect_at(1, 6'h3F, 3'd0, {nm, "_in_reset"});
        step(2);
        Reset = 1'b0;
        expect_at(1, post, 3'd0, {nm, "_after_release"});
        step(2);
    endtask

    task automatic toggle(input logic [5:0] p, input logic [2:0] ph,
                          input string nm, input int hold);
        Select = ~Select;
        expect_at(3, p, ph, nm);
        step(hold);
    endtask

    initial begin
        Reset       = 1'b1;
        Select      = 1'b1;
        Buttons     = 12'h000;
        SixButtonEn = 1'b1;
        step(1);

        // reset state and idle phase 0
        do_reset(6'h3F, "reset");
        n_chk++;
        if ({Pino9, Pino6, Pino4, Pino3, Pino2, Pino1} === 6'h3F && Phase === 3'd0)
            n_pass++;
        else
            $display("FAIL direct_reset: pins=%b phase=%0d",
                     {Pino9, Pino6, Pino4, Pino3, Pino2, Pino1}, Phase);

        // Up + A, then a falling Select edge
        Buttons = 12'h011;
        expect_at(1, 6'h3E, 3'd0, "ph0_up");
        step(2);
        Select = 1'b0;
        expect_at(2, 6'h3E, 3'd0, "sel_latency_hold");
        expect_at(3, 6'h22, 3'd1, "ph1_up_a");
        step(5);
        Buttons = 12'h013;
        expect_at(1, 6'h20, 3'd1, "button_follow");
        step(3);

        // six-button sequence, Z pressed
        Select  = 1'b1;
        Buttons = 12'h400;
        do_reset(6'h3F, "reset6");
        toggle(6'h33, 3'd1, "six_ph1", HP);
        toggle(6'h3F, 3'd2, "six_ph2", HP);
        toggle(6'h33, 3'd3, "six_ph3", HP);
        toggle(6'h3F, 3'd4, "six_ph4", HP);
        toggle(6'h30, 3'd5, "six_ph5", HP);
        toggle(6'h3E, 3'd6, "six_ph6", HP);
        toggle(6'h3F, 3'd7, "six_ph7", HP);
        n_chk++;
        if (Phase === 3'd7 && Pino1 === 1'b1 && Pino4 === 1'b1)
            n_pass++;
        else
            $display("FAIL direct_ph7: phase=%0d", Phase);
        toggle(6'h3F, 3'd0, "six_wrap0", HP);

        // three-button mode; enable rises mid-sequence and must be ignored
        SixButtonEn = 1'b0;
        step(2);
        toggle(6'h33, 3'd1, "three_ph1", HP);
        toggle(6'h3F, 3'd2, "three_ph2", HP);
        toggle(6'h33, 3'd3, "three_ph3", HP);
        SixButtonEn = 1'b1;
        toggle(6'h3F, 3'd4, "three_ph4", HP);
        toggle(6'h33, 3'd5, "three_ph5", HP);
        toggle(6'h3F, 3'd6, "three_ph6", HP);
        toggle(6'h33, 3'd7, "three_ph7", HP);
        toggle(6'h3F, 3'd0, "three_wrap0", HP);

        // timeouts
        Buttons = 12'h000;
        toggle(6'h33, 3'd1, "to_ph1", HP);
        toggle(6'h3F, 3'd2, "to_ph2", HP);
        Select = 1'b0;
        expect_at(3, 6'h33, 3'd3, "to_ph3");
        expect_at(T + 3, 6'h33, 3'd3, "to_low_pre");
        expect_at(T + 4, 6'h33, 3'd1, "to_low_fire");
        step(T + 10);
        toggle(6'h3F, 3'd2, "to_ph2b", HP);
        toggle(6'h33, 3'd3, "to_ph3b", HP);
        Select = 1'b1;
        expect_at(3, 6'h3F, 3'd4, "to_ph4");
        expect_at(T + 3, 6'h3F, 3'd4, "to_high_pre");
        expect_at(T + 4, 6'h3F, 3'd0, "to_high_fire");
        step(T + 10);
        n_chk++;
        if (Phase === 3'd0)
            n_pass++;
        else
            $display("FAIL direct_timeout_high: phase=%0d", Phase);

        // edge on the saturation cycle
        Select = 1'b0;
        expect_at(3, 6'h33, 3'd1, "sat_ph1");
        step(T + 1);
        Select = 1'b1;
        expect_at(2, 6'h33, 3'd1, "sat_pre");
        expect_at(3, 6'h3F, 3'd2, "sat_edge_wins");
        expect_at(4, 6'h3F, 3'd2, "sat_hold");
        step(10);

        // reset during phase 6, Down + Z pressed
        Buttons = 12'h402;
        do_reset(6'h3D, "reset_pre");
        toggle(6'h31, 3'd1, "rs_ph1", 20);
        toggle(6'h3D, 3'd2, "rs_ph2", 20);
        toggle(6'h31, 3'd3, "rs_ph3", 20);
        toggle(6'h3D, 3'd4, "rs_ph4", 20);
        toggle(6'h30, 3'd5, "rs_ph5", 20);
        toggle(6'h3E, 3'd6, "rs_ph6", 20);
        do_reset(6'h3D, "reset_mid");
        n_chk++;
        if ({Pino9, Pino6, Pino4, Pino3, Pino2, Pino1} === 6'h3D && Phase === 3'd0)
            n_pass++;
        else
            $display("FAIL direct_reset_mid: pins=%b phase=%0d",
                     {Pino9, Pino6, Pino4, Pino3, Pino2, Pino1}, Phase);

        step(5);
        while (q.size() != 0) begin
            n_chk++;
            $display("FAIL %s: never checked, expected pins=%b phase=%0d",
                     q[0].name, q[0].pins, q[0].ph);
            void'(q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        if (n_pass == n_chk)
            $display("TEST PASSED");
        else
            $display("TEST FAILED");
        $finish;
    end

endmodule
